gold_code_correlator: RTL and testbench
=======================================

Name: gold_code_correlator

Overview:
- Downstream consumer of the Gold/LFSR code generator: despreads a received chip stream against the locally generated code.
- Accumulates ±1 chip agreements over one code period (N = 2^M − 1 chips), framed by the generator's sync_bit.
- Emits one signed correlation sum and one hard-decision data bit per period.
- Tracks code lock with a consecutive-period hysteresis counter.

Parameters:
- M, 3, LFSR order; code period N = 2^M − 1 chips.
- LOCK_THRESH, 5, minimum |correlation| for a "good" period (must be ≤ N).
- LOCK_COUNT, 2, consecutive good periods required to assert locked.
- LOSS_COUNT, 2, consecutive bad periods required to deassert locked.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- chip_valid  in  1  qualifies rx_chip, code_bit and sync_bit for this cycle.
- rx_chip  in  1  received hard-decision chip.
- code_bit  in  1  local code chip from the generator's output_bit.
- sync_bit  in  1  generator sync_bit; high on the first chip of each code period.
- corr_out  out  M+2  signed two's-complement correlation sum of the last period.
- corr_valid  out  1  one-cycle pulse when corr_out is updated.
- data_bit  out  1  despread decision: 1 if corr_out ≥ 0, else 0. Updated with corr_valid.
- locked  out  1  code-lock indicator.
- sync_error  out  1  one-cycle pulse on period framing violation.

Behaviour:
- Reset (asserted low, asynchronous): corr_out=0, corr_valid=0, data_bit=0, locked=0, sync_error=0, acc=0, chip_cnt=0, good/bad counters=0, state=IDLE. Reset mid-period discards the partial sum.
- Chip contribution: c = +1 if rx_chip == code_bit, else −1. Only cycles with chip_valid=1 are processed; cycles with chip_valid=0 hold all state. sync_bit is ignored when chip_valid=0.
- Accumulator: signed, M+2 bits. Range [−N, +N]; it never overflows.
- State IDLE:
  - Wait for chip_valid & sync_bit.
  - On that cycle: acc ← c, chip_cnt ← 1, go to ACCUM.
- State ACCUM, on each chip_valid:
  - sync_bit=1 and chip_cnt < N (early sync): sync_error pulse next cycle; no corr_valid; acc ← c; chip_cnt ← 1; remain in ACCUM.
  - sync_bit=0 and chip_cnt == N (missing sync): sync_error pulse; go to IDLE; acc cleared.
  - sync_bit=1 and chip_cnt == N (normal period start): acc ← c, chip_cnt ← 1.
  - Otherwise: acc ← acc + c; chip_cnt ← chip_cnt + 1.
  - When this update makes chip_cnt reach N: the registered outputs take the final sum on the same edge. corr_out ← acc + c, data_bit ← (sum ≥ 0), and corr_valid is high for exactly the following cycle.
  - Latency: corr_valid is visible 1 clock after the clock edge that accepts the Nth chip.
- Lock tracking (evaluated only on corr_valid):
  - good = |corr_out| ≥ LOCK_THRESH.
  - Good period: good_cnt saturating increment, bad_cnt ← 0.
  - Bad period: bad_cnt saturating increment, good_cnt ← 0.
  - locked rises in the same cycle corr_valid is high when good_cnt reaches LOCK_COUNT.
  - locked falls in the same cycle corr_valid is high when bad_cnt reaches LOSS_COUNT.
- Any sync_error forces locked=0 and clears both counters in the same cycle the pulse is high.
- Simultaneous events: sync_error and corr_valid are never high in the same cycle.
- Back-to-back chips (chip_valid every cycle) are fully supported with no stall; the block has no back-pressure.

Decomposition:
- Shared package gold_code_pkg holds:
  - function code_len(M) = 2^M − 1;
  - accumulator width constant ACC_W = M+2;
  - enumerated state type {IDLE, ACCUM}.
  The generator and correlator share this package.
- One natural sub-module: gold_code_lock_detector. It takes corr_valid, corr_out, sync_error and parameters LOCK_THRESH/LOCK_COUNT/LOSS_COUNT, and outputs locked.

Test Plan:
- M=3, rx_chip = code_bit for 7 chips, sync_bit on chip 1, chip_valid every cycle -> corr_valid one cycle after 7th chip, corr_out = +7, data_bit = 1, sync_error = 0.
- Same with rx_chip inverted -> corr_out = −7 (5'b11001), data_bit = 0; repeat twice -> locked = 1 on 2nd corr_valid.
- Locked, then two periods with 3 mismatched chips (corr_out = +1, below threshold 5) -> locked drops on 2nd such corr_valid; data_bit = 1 both times.
- Random chip_valid gaps (1–3 idle cycles between chips) with matching data -> identical corr_out = +7; no spurious pulses during gaps.
- sync_bit asserted at chip 4 of a period while locked -> sync_error pulse, locked = 0 same cycle, no corr_valid; next 7 matched chips give corr_out = +7. Sync missing after chip 7 -> sync_error, return to IDLE.
- Reset asserted mid-period (chip 3) -> all outputs 0 immediately, without waiting for a clock edge. After release, first corr_valid only after a fresh sync plus 7 chips.

Source files
------------

// File: rtl/gold_code_pkg.sv
// Shared definitions for the Gold/LFSR code generator and its correlator.
package gold_code_pkg;

    localparam int unsigned GOLD_M = 3;
    localparam int unsigned ACC_W  = GOLD_M + 2;

    typedef enum logic {
        IDLE,
        ACCUM
    } corr_state_t;

    // Code period in chips for an LFSR of order m.
    function automatic int unsigned code_len(input int unsigned m);
        return (32'd1 << m) - 32'd1;
    endfunction

    // Accumulator stays two bits wider than the LFSR order for any m.
    function automatic int unsigned acc_width(input int unsigned m);
        return ACC_W - GOLD_M + m;
    endfunction

endpackage

// File: rtl/gold_code_correlator_if.sv
// Chip stream in, per-period correlation results out.
interface gold_code_correlator_if
    import gold_code_pkg::*;
#(
    parameter int unsigned M = GOLD_M
) ();

    localparam int unsigned W = acc_width(M);

    logic         chip_valid;
    logic         rx_chip;
    logic         code_bit;
    logic         sync_bit;
    logic [W-1:0] corr_out;
    logic         corr_valid;
    logic         data_bit;
    logic         locked;
    logic         sync_error;

    modport master (
        output chip_valid, rx_chip, code_bit, sync_bit,
        input  corr_out, corr_valid, data_bit, locked, sync_error
    );

    modport slave (
        input  chip_valid, rx_chip, code_bit, sync_bit,
        output corr_out, corr_valid, data_bit, locked, sync_error
    );

endinterface

// File: rtl/gold_code_lock_detector.sv
// Consecutive-period hysteresis on |correlation|; fed with next-cycle pulses so
// locked changes in the same cycle the corresponding pulse is visible.
module gold_code_lock_detector
    import gold_code_pkg::*;
#(
    parameter int unsigned M           = GOLD_M,
    parameter int unsigned LOCK_THRESH = 5,
    parameter int unsigned LOCK_COUNT  = 2,
    parameter int unsigned LOSS_COUNT  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     corr_valid,
    input  logic [acc_width(M)-1:0]  corr_out,
    input  logic                     sync_error,
    output logic                     locked
);

    localparam int unsigned W       = acc_width(M);
    localparam int unsigned SAT_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int unsigned CNT_W   = $clog2(SAT_MAX + 1);

    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             locked_q, locked_d;
    logic [W-1:0]     mag;
    logic             good;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
        end
    end

    // |corr| of a two's-complement sum; -N is always representable.
    always_comb begin
        mag  = corr_out[W-1] ? (~corr_out + W'(1)) : corr_out;
        good = (mag >= W'(LOCK_THRESH));
    end

    always_comb begin
        good_d   = good_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        if (sync_error) begin
            good_d   = '0;
            bad_d    = '0;
            locked_d = 1'b0;
        end else if (corr_valid) begin
            if (good) begin
                bad_d  = '0;
                good_d = (good_q == CNT_W'(LOCK_COUNT)) ? good_q : good_q + CNT_W'(1);
                if (good_d == CNT_W'(LOCK_COUNT)) begin
                    locked_d = 1'b1;
                end
            end else begin
                good_d = '0;
                bad_d  = (bad_q == CNT_W'(LOSS_COUNT)) ? bad_q : bad_q + CNT_W'(1);
                if (bad_d == CNT_W'(LOSS_COUNT)) begin
                    locked_d = 1'b0;
                end
            end
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/gold_code_correlator.sv
// Despreads a received chip stream against the local Gold code, one signed sum
// and one hard data decision per code period, with code-lock tracking.
module gold_code_correlator
    import gold_code_pkg::*;
#(
    parameter int unsigned M           = GOLD_M,
    parameter int unsigned LOCK_THRESH = 5,
    parameter int unsigned LOCK_COUNT  = 2,
    parameter int unsigned LOSS_COUNT  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    gold_code_correlator_if.slave bus
);

    localparam int unsigned N    = code_len(M);
    localparam int unsigned W    = acc_width(M);
    localparam int unsigned CW   = M;

    corr_state_t   state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  corr_q, corr_d;
    logic          data_q, data_d;
    logic          corr_valid_q, corr_valid_d;
    logic          sync_err_q, sync_err_d;
    logic [W-1:0]  chip_c;
    logic [W-1:0]  sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            corr_q       <= '0;
            data_q       <= 1'b0;
            corr_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            corr_q       <= corr_d;
            data_q       <= data_d;
            corr_valid_q <= corr_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        corr_d       = corr_q;
        data_d       = data_q;
        corr_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        chip_c       = (bus.rx_chip == bus.code_bit) ? W'(1) : {W{1'b1}};
        sum          = acc_q + chip_c;

        case (state_q)
            IDLE: begin
                if (bus.chip_valid && bus.sync_bit) begin
                    acc_d   = chip_c;
                    cnt_d   = CW'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.chip_valid) begin
                    if (bus.sync_bit && (cnt_q != CW'(N))) begin
                        // Early sync: restart the period on this chip.
                        sync_err_d = 1'b1;
                        acc_d      = chip_c;
                        cnt_d      = CW'(1);
                    end else if (!bus.sync_bit && (cnt_q == CW'(N))) begin
                        // Missing sync: drop framing and wait for a fresh one.
                        sync_err_d = 1'b1;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else if (bus.sync_bit) begin
                        acc_d = chip_c;
                        cnt_d = CW'(1);
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) begin
                            corr_d       = sum;
                            data_d       = ~sum[W-1];
                            corr_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    gold_code_lock_detector #(
        .M           (M),
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_COUNT  (LOCK_COUNT),
        .LOSS_COUNT  (LOSS_COUNT)
    ) u_lock (
        .clock      (clock),
        .reset      (reset),
        .corr_valid (corr_valid_d),
        .corr_out   (corr_d),
        .sync_error (sync_err_d),
        .locked     (bus.locked)
    );

    assign bus.corr_out   = corr_q;
    assign bus.corr_valid = corr_valid_q;
    assign bus.data_bit   = data_q;
    assign bus.sync_error = sync_err_q;

endmodule

// File: tb/tb_gold_code_correlator.sv
// Scoreboard bench for gold_code_correlator (M=3, N=7).
module tb_gold_code_correlator;

    localparam int unsigned M      = 3;
    localparam int          N      = 7;
    localparam int unsigned W      = 5;
    localparam int          THRESH = 5;
    localparam int          LCNT   = 2;
    localparam int          LOSS   = 2;
    localparam logic [6:0]  CODE   = 7'b1110100;

    typedef struct {
        logic [W-1:0] corr;
        logic         data;
        logic         lk;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sync_pending = 0;
    int   m_good = 0;
    int   m_bad  = 0;
    logic m_locked = 1'b0;

    always #5 clock = ~clock;

    gold_code_correlator_if #(.M(M)) bus ();

    gold_code_correlator #(
        .M           (M),
        .LOCK_THRESH (THRESH),
        .LOCK_COUNT  (LCNT),
        .LOSS_COUNT  (LOSS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Output monitor: every pulse must be expected.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.corr_valid && bus.sync_error) begin
                n_checks++; n_fail++;
                $display("FAIL pulse_overlap: corr_valid and sync_error both high at %0t", $time);
            end
            if (bus.corr_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_corr_valid: corr_out=%0d with nothing expected at %0t",
                             $signed(bus.corr_out), $time);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.corr_out !== mon_e.corr) begin
                        n_fail++;
                        $display("FAIL corr_out: got %b expected %b at %0t", bus.corr_out, mon_e.corr, $time);
                    end
                    n_checks++;
                    if (bus.data_bit !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL data_bit: got %b expected %b at %0t", bus.data_bit, mon_e.data, $time);
                    end
                    n_checks++;
                    if (bus.locked !== mon_e.lk) begin
                        n_fail++;
                        $display("FAIL locked_at_corr: got %b expected %b at %0t", bus.locked, mon_e.lk, $time);
                    end
                end
            end
            if (bus.sync_error) begin
                n_checks++;
                if (sync_pending == 0) begin
                    n_fail++;
                    $display("FAIL spurious_sync_error: unexpected pulse at %0t", $time);
                end else begin
                    sync_pending--;
                end
                n_checks++;
                if (bus.locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL locked_at_sync_error: got %b expected 0 at %0t", bus.locked, $time);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_period(input int sum);
        int mag;
        mag = (sum < 0) ? -sum : sum;
        if (mag >= THRESH) begin
            m_bad = 0;
            if (m_good < LCNT) m_good++;
            if (m_good == LCNT) m_locked = 1'b1;
        end else begin
            m_good = 0;
            if (m_bad < LOSS) m_bad++;
            if (m_bad == LOSS) m_locked = 1'b0;
        end
    endfunction

    function automatic void model_clear();
        m_good   = 0;
        m_bad    = 0;
        m_locked = 1'b0;
    endfunction

    task automatic drive_chip(input logic rx, input logic code, input logic sync);
        bus.chip_valid = 1'b1;
        bus.rx_chip    = rx;
        bus.code_bit   = code;
        bus.sync_bit   = sync;
        @(posedge clock);
        #1;
        bus.chip_valid = 1'b0;
    endtask

    // Idle cycles carry junk on the qualified inputs, which must be ignored.
    task automatic gap_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            bus.rx_chip  = 1'($urandom);
            bus.sync_bit = 1'($urandom);
            bus.code_bit = 1'($urandom);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_period(input logic [6:0] flip, input int max_gap);
        int   sum;
        exp_t e;
        sum = N - 2 * $countones(flip);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                model_period(sum);
                e.corr = W'(sum);
                e.data = (sum >= 0);
                e.lk   = m_locked;
                sb.push_back(e);
            end
            drive_chip(CODE[i] ^ flip[i], CODE[i], (i == 0));
            if (max_gap > 0) gap_cycles($urandom_range(max_gap, 1));
        end
    endtask

    task automatic check_drain(input string name);
        for (int k = 0; k < 8 && (sb.size() != 0 || sync_pending != 0); k++) begin
            @(posedge clock);
            #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_corr_timeout: %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        n_checks++;
        if (sync_pending != 0) begin
            n_fail++;
            $display("FAIL %s_sync_timeout: %0d sync_error pulses outstanding, expected 0", name, sync_pending);
            sync_pending = 0;
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (bus.corr_out !== '0) begin n_fail++; $display("FAIL %s_corr_out: got %b expected 0", name, bus.corr_out); end
        n_checks++;
        if (bus.corr_valid !== 1'b0) begin n_fail++; $display("FAIL %s_corr_valid: got %b expected 0", name, bus.corr_valid); end
        n_checks++;
        if (bus.data_bit !== 1'b0) begin n_fail++; $display("FAIL %s_data_bit: got %b expected 0", name, bus.data_bit); end
        n_checks++;
        if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL %s_locked: got %b expected 0", name, bus.locked); end
        n_checks++;
        if (bus.sync_error !== 1'b0) begin n_fail++; $display("FAIL %s_sync_error: got %b expected 0", name, bus.sync_error); end
    endtask

    task automatic test_reset();
        bus.chip_valid = 1'b0;
        bus.rx_chip    = 1'b0;
        bus.code_bit   = 1'b0;
        bus.sync_bit   = 1'b0;
        reset          = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        gap_cycles(2);
    endtask

    task automatic test_match();
        send_period(7'h00, 0);
        check_drain("match");
    endtask

    task automatic test_inverted();
        send_period(7'h7F, 0);
        send_period(7'h7F, 0);
        check_drain("inverted");
    endtask

    task automatic test_below_thresh();
        send_period(7'b0100101, 0);
        send_period(7'b1010010, 0);
        check_drain("below_thresh");
    endtask

    task automatic test_gaps();
        send_period(7'h00, 3);
        send_period(7'h00, 3);
        check_drain("gaps");
    endtask

    task automatic test_sync_errors();
        n_checks++;
        if (bus.locked !== m_locked) begin
            n_fail++;
            $display("FAIL early_sync_prelock: got %b expected %b", bus.locked, m_locked);
        end
        for (int i = 0; i < 3; i++) drive_chip(CODE[i], CODE[i], (i == 0));
        sync_pending++;
        model_clear();
        send_period(7'h00, 0);
        check_drain("early_sync");
        // Period complete; a chip without sync must drop framing.
        sync_pending++;
        model_clear();
        drive_chip(CODE[0], CODE[0], 1'b0);
        for (int i = 1; i < 4; i++) drive_chip(CODE[i], CODE[i], 1'b0);
        send_period(7'h00, 0);
        check_drain("missing_sync");
    endtask

    task automatic test_reset_mid();
        send_period(7'h00, 0);
        check_drain("pre_reset");
        for (int i = 0; i < 3; i++) drive_chip(CODE[i], CODE[i], (i == 0));
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) drive_chip(CODE[i], CODE[i], 1'b0);
        send_period(7'h00, 0);
        check_drain("post_reset");
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 6; p++) send_period(7'($urandom), 0);
        check_drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_match();
        test_inverted();
        test_below_thresh();
        test_gaps();
        test_sync_errors();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
